// File: rtl/mac_package.sv
// Shared HWPE engine types: AES sequencing states, widths and control/flag bundles.
package mac_package;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES_SCHED_CNT_W = 16;

    typedef enum logic [2:0] {
        AES_IDLE    = 3'd0,
        AES_WAIT_IN = 3'd1,
        AES_RUN     = 3'd2,
        AES_OUT     = 3'd3,
        AES_DONE    = 3'd4
    } aes_sched_state_t;

    typedef struct packed {
        logic                       start;
        logic [AES_SCHED_CNT_W-1:0] len;
        logic                       cbc_en;
    } aes_sched_ctrl_t;

    typedef struct packed {
        logic done;
        logic err;
    } aes_sched_flags_t;

endpackage

// File: rtl/aes_cbc_sched.sv
// Job sequencer for the 128-bit AES core: gates stacked text/key into load pulses,
// owns the CBC chaining register, buffers results and watches for a hung core.
module aes_cbc_sched
    import mac_package::*;
#(
    parameter int CNT_W   = AES_SCHED_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       len_i,
    input  logic                   cbc_en_i,
    input  logic [AES_BLOCK_W-1:0] iv_i,
    input  logic                   word_valid_i,
    input  logic [AES_BLOCK_W-1:0] word_i,
    output logic                   word_ready_o,
    input  logic                   key_valid_i,
    input  logic [AES_BLOCK_W-1:0] key_i,
    output logic                   key_ready_o,
    output logic                   aes_ld_o,
    output logic [AES_BLOCK_W-1:0] aes_text_o,
    output logic [AES_BLOCK_W-1:0] aes_key_o,
    input  logic                   aes_done_i,
    input  logic [AES_BLOCK_W-1:0] aes_out_i,
    output logic                   res_valid_o,
    output logic [AES_BLOCK_W-1:0] res_data_o,
    input  logic                   res_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [CNT_W-1:0]       cnt_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    aes_sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cbc_q, cbc_d;
    logic [AES_BLOCK_W-1:0] chain_q, chain_d;
    logic [AES_BLOCK_W-1:0] res_q, res_d;
    logic                   err_q, err_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    logic                   soft_rst;
    logic                   ld;
    logic [CNT_W-1:0]       cnt_inc;
    aes_sched_flags_t       flags;

    assign soft_rst = rst_i | clear_i;
    // Load must never fire in a reset/clear cycle, even if both streams are valid.
    assign ld       = (state_q == AES_WAIT_IN) & word_valid_i & key_valid_i & ~soft_rst;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        cbc_d   = cbc_q;
        chain_d = chain_q;
        res_d   = res_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            AES_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        cbc_d   = cbc_en_i;
                        chain_d = iv_i;
                        state_d = AES_WAIT_IN;
                    end else begin
                        state_d = AES_DONE;
                    end
                end
            end
            AES_WAIT_IN: begin
                if (ld) begin
                    timer_d = '0;
                    state_d = AES_RUN;
                end
            end
            AES_RUN: begin
                // done has priority over an expiring timer in the same cycle
                if (aes_done_i) begin
                    res_d   = aes_out_i;
                    if (cbc_q) chain_d = aes_out_i;
                    state_d = AES_OUT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = AES_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            AES_OUT: begin
                if (res_ready_i) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? AES_DONE : AES_WAIT_IN;
                end
            end
            AES_DONE: state_d = AES_IDLE;
            default:  state_d = AES_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q <= AES_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            cbc_q   <= 1'b0;
            chain_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            cbc_q   <= cbc_d;
            chain_q <= chain_d;
            res_q   <= res_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign flags.done = (state_q == AES_DONE);
    assign flags.err  = err_q;

    assign word_ready_o = ld;
    assign key_ready_o  = ld;
    assign aes_ld_o     = ld;
    assign aes_text_o   = ld ? (cbc_q ? (word_i ^ chain_q) : word_i) : '0;
    assign aes_key_o    = ld ? key_i : '0;
    assign res_valid_o  = (state_q == AES_OUT);
    assign res_data_o   = res_q;
    assign busy_o       = (state_q != AES_IDLE);
    assign done_o       = flags.done;
    assign err_o        = flags.err;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_aes_cbc_sched.sv
// Directed bench for aes_cbc_sched with a stub core: out = text ^ key, done 10 cycles after ld.
module tb_aes_cbc_sched;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0, cbc_en_i = 1'b0;
    logic [CNT_W-1:0] len_i = '0;
    logic [127:0]     iv_i = '0, word_i = '0, key_i = '0;
    logic             word_valid_i = 1'b0, key_valid_i = 1'b0, res_ready_i = 1'b1;
    logic             word_ready_o, key_ready_o, aes_ld_o, res_valid_o;
    logic             busy_o, done_o, err_o;
    logic [127:0]     aes_text_o, aes_key_o, res_data_o;
    logic [CNT_W-1:0] cnt_o;
    logic             aes_done_i = 1'b0;
    logic [127:0]     stub_out = '0;
    int               stub_cnt = 0;
    logic             stub_hang = 1'b0;

    int n_vec = 0, n_err = 0;
    int ld_cnt = 0, done_cnt = 0;

    localparam logic [127:0] W_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_A   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R_A   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] IV_A  = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes_cbc_sched #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .cbc_en_i(cbc_en_i), .iv_i(iv_i),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .key_valid_i(key_valid_i), .key_i(key_i), .key_ready_o(key_ready_o),
        .aes_ld_o(aes_ld_o), .aes_text_o(aes_text_o), .aes_key_o(aes_key_o),
        .aes_done_i(aes_done_i), .aes_out_i(stub_out),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cnt_o(cnt_o)
    );

    // stub core; keeps counting through a DUT reset so a late done can be produced
    always @(posedge clk) begin
        aes_done_i <= 1'b0;
        if (aes_ld_o) begin
            stub_out <= aes_text_o ^ aes_key_o;
            stub_cnt <= 10;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_hang) aes_done_i <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (aes_ld_o) ld_cnt <= ld_cnt + 1;
        if (done_o)   done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return aes_ld_o;
            1:       return res_valid_o;
            default: return err_o;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int s, input int max);
        int c = 0;
        while (!sig(s) && c < max) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {127'd0, sig(s)}, 128'd1);
    endtask

    task automatic start_job(input int len, input logic cbc, input logic [127:0] iv);
        start_i  = 1'b1;
        len_i    = CNT_W'(len);
        cbc_en_i = cbc;
        iv_i     = iv;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // one block: load seen with expected text, result seen, handshake edge consumed
    task automatic run_block(input string tag, input logic [127:0] exp_text, input logic [127:0] exp_res);
        wait_sig({tag, "_ld"}, 0, 10);
        chk({tag, "_text"}, aes_text_o, exp_text);
        chk({tag, "_rdy"}, {126'd0, word_ready_o, key_ready_o}, 128'd3);
        wait_sig({tag, "_rv"}, 1, 40);
        chk({tag, "_res"}, res_data_o, exp_res);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int c;
        logic ok;
        word_i = W_A;
        key_i  = K_A;
        word_valid_i = 1'b1;
        key_valid_i  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ld", {127'd0, aes_ld_o}, 128'd0);
        rst_i = 1'b0;
        chk("rst_outs", {123'd0, busy_o, res_valid_o, done_o, err_o, word_ready_o}, 128'd0);
        chk("rst_cnt", {112'd0, cnt_o}, 128'd0);

        // ECB single block
        base = ld_cnt;
        start_job(1, 1'b0, '0);
        run_block("ecb", W_A, R_A);
        chk("ecb_key", {127'd0, done_o}, 128'd1);
        @(negedge clk);
        chk("ecb_end", {126'd0, done_o, busy_o}, 128'd0);
        chk("ecb_cnt", {112'd0, cnt_o}, 128'd1);
        chk("ecb_nld", 128'(ld_cnt - base), 128'd1);

        // CBC two blocks, zero key and words: each load text equals iv
        word_i = '0;
        key_i  = '0;
        start_job(2, 1'b1, IV_A);
        run_block("cbc0", IV_A, IV_A);
        chk("cbc_mid_done", {127'd0, done_o}, 128'd0);
        run_block("cbc1", IV_A, IV_A);
        chk("cbc_done", {127'd0, done_o}, 128'd1);
        @(negedge clk);
        chk("cbc_cnt", {112'd0, cnt_o}, 128'd2);

        // backpressure in OUT
        word_i = W_A;
        key_i  = K_A;
        res_ready_i = 1'b0;
        base = ld_cnt;
        start_job(2, 1'b0, '0);
        wait_sig("bp_rv", 1, 40);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!res_valid_o || res_data_o !== R_A || word_ready_o || aes_ld_o) ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", {127'd0, ok}, 128'd1);
        chk("bp_nld", 128'(ld_cnt - base), 128'd1);
        res_ready_i = 1'b1;
        @(negedge clk);
        run_block("bp1", W_A, R_A);
        chk("bp_done", {127'd0, done_o}, 128'd1);
        @(negedge clk);
        chk("bp_cnt", {112'd0, cnt_o}, 128'd2);

        // timeout: core never finishes
        stub_hang = 1'b1;
        base = done_cnt;
        start_job(1, 1'b0, '0);
        chk("to_ld", {127'd0, aes_ld_o}, 128'd1);
        for (int i = 0; i < TIMEOUT; i++) @(negedge clk);
        chk("to_early", {126'd0, err_o, busy_o}, 128'd1);
        @(negedge clk);
        chk("to_err", {126'd0, err_o, busy_o}, 128'd2);
        chk("to_nodone", 128'(done_cnt - base), 128'd0);
        stub_hang = 1'b0;

        // zero-length job also clears the sticky error
        base = ld_cnt;
        start_job(0, 1'b0, '0);
        chk("len0_done", {126'd0, done_o, err_o}, 128'd2);
        @(negedge clk);
        chk("len0_end", {127'd0, done_o}, 128'd0);
        chk("len0_cnt", {112'd0, cnt_o}, 128'd0);
        chk("len0_nld", 128'(ld_cnt - base), 128'd0);

        // reset during RUN of block 3 of 5
        base = ld_cnt;
        start_job(5, 1'b0, '0);
        c = 0;
        while (ld_cnt < base + 3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("mid_reach", {127'd0, ld_cnt == base + 3}, 128'd1);
        @(negedge clk);
        chk("mid_run", {112'd0, cnt_o}, 128'd2);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mid_outs", {123'd0, busy_o, res_valid_o, done_o, err_o, aes_ld_o}, 128'd0);
        chk("mid_data", res_data_o, 128'd0);
        chk("mid_cnt", {112'd0, cnt_o}, 128'd0);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (busy_o || res_valid_o || aes_ld_o) ok = 1'b0;
            @(negedge clk);
        end
        chk("late_done_ign", {127'd0, ok}, 128'd1);

        // fresh job after the reset
        start_job(2, 1'b0, '0);
        run_block("re0", W_A, R_A);
        run_block("re1", W_A, R_A);
        chk("re_done", {127'd0, done_o}, 128'd1);
        @(negedge clk);
        chk("re_cnt", {112'd0, cnt_o}, 128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
